// File: rtl/mult_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mult_arbiter_pkg
//
// Shared definitions for the multiplier arbiter slice:
//   - state_t          : 2-bit FSM state encoding (IDLE, ISSUE, WAIT, RESPOND)
//   - DEFAULT_N        : default number of requesters
//   - DEFAULT_W        : default operand width
//   - DEFAULT_TIMEOUT  : default WAIT-state abort limit in cycles
//   - idx_width()      : width of an index able to address n items (min 1 bit)
// -----------------------------------------------------------------------------
package mult_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_WAIT    = 2'b10,
        ST_RESPOND = 2'b11
    } state_t;

    localparam int DEFAULT_N       = 4;
    localparam int DEFAULT_W       = 8;
    localparam int DEFAULT_TIMEOUT = 64;

    // Bits needed to hold values 0..n-1; never returns 0 so that a vector
    // declared with it is always legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : mult_arbiter_pkg

// File: rtl/mult_arbiter_rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
//
// Combinational round-robin first-set-bit finder. Starting at position Ptr
// and wrapping from N-1 back to 0, returns the index of the first set bit of
// Req.
//
// Ports:
//   Req    in  N   request vector
//   Ptr    in  PW  search start position (0..N-1)
//   G      out PW  index of the selected requester (0 when nothing is set)
//   Valid  out 1   high when at least one Req bit is set
// -----------------------------------------------------------------------------
module rr_select
    import mult_arbiter_pkg::*;
#(
    parameter  int N  = DEFAULT_N,
    localparam int PW = idx_width(N)
) (
    input  logic [N-1:0]  Req,
    input  logic [PW-1:0] Ptr,
    output logic [PW-1:0] G,
    output logic          Valid
);

    // rot_idx[k] is the requester index sitting k places after Ptr, so that
    // req_rot is Req rotated to put the highest-priority requester at bit 0.
    logic [PW-1:0] rot_idx [N];
    logic [N-1:0]  req_rot;

    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        // One extra bit so Ptr + gi cannot overflow before the wrap test,
        // which matters when N is not a power of two.
        logic [PW:0] sum;

        assign sum          = {1'b0, Ptr} + (PW+1)'(gi);
        assign rot_idx[gi]  = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N))
                                                  : sum[PW-1:0];
        assign req_rot[gi]  = Req[rot_idx[gi]];
    end

    // Scan from the lowest priority upward so the last hit written is the
    // highest-priority (closest to Ptr) set bit.
    always_comb begin
        G     = '0;
        Valid = 1'b0;
        for (int k = N-1; k >= 0; k--) begin
            if (req_rot[k]) begin
                G     = rot_idx[k];
                Valid = 1'b1;
            end
        end
    end

endmodule : rr_select

// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
//
// Round-robin arbiter that shares one external shift-add multiplier among N
// requesters. A requester raises Req and holds it until it receives a
// one-cycle Ack carrying the 2*W-bit unsigned product on Result. If the
// multiplier does not report Mul_Done within TIMEOUT cycles of waiting, the
// operation is aborted and acknowledged with Error=1 and Result=0.
//
// Ports:
//   Clock             in  1      rising-edge clock
//   Reset             in  1      asynchronous, active-high reset
//   Req               in  N      request levels, held until Ack
//   Operand_A         in  N*W    multiplicands, requester i at [i*W +: W]
//   Operand_B         in  N*W    multipliers, same packing
//   Ack               out N      one-hot completion pulse
//   Result            out 2*W    product, valid while Ack is high
//   Error             out 1      timeout flag, valid while Ack is high
//   Busy              out 1      high whenever the FSM is not IDLE
//   Mul_Start         out 1      one-cycle start pulse to the multiplier
//   Mul_Multiplicand  out W      latched operand A for the multiplier
//   Mul_Multiplier    out W      latched operand B for the multiplier
//   Mul_Product       in  2*W    multiplier result
//   Mul_Done          in  1      multiplier completion level
// -----------------------------------------------------------------------------
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter  int N       = DEFAULT_N,
    parameter  int W       = DEFAULT_W,
    parameter  int TIMEOUT = DEFAULT_TIMEOUT,
    localparam int PW      = idx_width(N),
    localparam int CW      = idx_width(TIMEOUT)
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic [N-1:0]   Req,
    input  logic [N*W-1:0] Operand_A,
    input  logic [N*W-1:0] Operand_B,
    output logic [N-1:0]   Ack,
    output logic [2*W-1:0] Result,
    output logic           Error,
    output logic           Busy,
    output logic           Mul_Start,
    output logic [W-1:0]   Mul_Multiplicand,
    output logic [W-1:0]   Mul_Multiplier,
    input  logic [2*W-1:0] Mul_Product,
    input  logic           Mul_Done
);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t          state_reg;
    state_t          state_next;
    logic [PW-1:0]   ptr_reg;          // round-robin search start
    logic [PW-1:0]   g_reg;            // currently granted requester
    logic [W-1:0]    opa_reg;
    logic [W-1:0]    opb_reg;
    logic [CW-1:0]   count_reg;        // cycles spent in WAIT without Done
    logic [2*W-1:0]  product_reg;
    logic            error_reg;
    logic            respond_ack_reg;  // Req[G] still high when WAIT ended

    // -------------------------------------------------------------------------
    // Operand unpacking and arbitration
    // -------------------------------------------------------------------------
    logic [W-1:0]    opa_arr [N];
    logic [W-1:0]    opb_arr [N];
    logic [PW-1:0]   sel_g;
    logic            sel_valid;

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign opa_arr[gi] = Operand_A[gi*W +: W];
        assign opb_arr[gi] = Operand_B[gi*W +: W];
    end

    rr_select #(
        .N     (N)
    ) u_rr_select (
        .Req   (Req),
        .Ptr   (ptr_reg),
        .G     (sel_g),
        .Valid (sel_valid)
    );

    // -------------------------------------------------------------------------
    // WAIT-state exit conditions. Done is checked before the timeout so a
    // Done arriving on the last permitted cycle still completes normally.
    // -------------------------------------------------------------------------
    logic timeout_hit;

    assign timeout_hit = (count_reg == CW'(TIMEOUT - 1));

    // -------------------------------------------------------------------------
    // FSM process 1: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (sel_valid) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Mul_Done may still be high from the previous operation;
                // it is deliberately not looked at here.
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (Mul_Done || timeout_hit) begin
                    state_next = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers, updated according to the current state
    // -------------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ptr_reg         <= '0;
            g_reg           <= '0;
            opa_reg         <= '0;
            opb_reg         <= '0;
            count_reg       <= '0;
            product_reg     <= '0;
            error_reg       <= 1'b0;
            respond_ack_reg <= 1'b0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    // Operands are captured at grant time, so later changes
                    // on Operand_A/B cannot disturb the running operation.
                    if (sel_valid) begin
                        g_reg   <= sel_g;
                        opa_reg <= opa_arr[sel_g];
                        opb_reg <= opb_arr[sel_g];
                    end
                end
                ST_ISSUE: begin
                    count_reg <= '0;
                end
                ST_WAIT: begin
                    if (Mul_Done) begin
                        product_reg     <= Mul_Product;
                        error_reg       <= 1'b0;
                        respond_ack_reg <= Req[g_reg];
                    end else if (timeout_hit) begin
                        product_reg     <= '0;
                        error_reg       <= 1'b1;
                        respond_ack_reg <= Req[g_reg];
                    end else begin
                        count_reg <= count_reg + CW'(1);
                    end
                end
                ST_RESPOND: begin
                    // Pointer moves past the served requester whether or not
                    // it was still there to take the Ack.
                    ptr_reg         <= (g_reg == PW'(N - 1)) ? '0
                                                             : g_reg + PW'(1);
                    respond_ack_reg <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 3: outputs. Everything here is decoded from registers only,
    // so no Req edge can ripple through to Ack or Mul_Start.
    // -------------------------------------------------------------------------
    logic ack_active;

    always_comb begin
        ack_active       = (state_reg == ST_RESPOND) && respond_ack_reg;
        Busy             = (state_reg != ST_IDLE);
        Mul_Start        = (state_reg == ST_ISSUE);
        Mul_Multiplicand = opa_reg;
        Mul_Multiplier   = opb_reg;
        Result           = ack_active ? product_reg : '0;
        Error            = ack_active && error_reg;
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_ack
        assign Ack[gi] = ack_active && (g_reg == PW'(gi));
    end

endmodule : mult_arbiter

// File: tb/tb_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_arbiter
//
// Directed testbench for mult_arbiter. A small behavioural multiplier answers
// Mul_Start after a programmable delay (or never, to force a timeout).
// All expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mult_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 16;

    logic           Clock = 1'b0;
    logic           Reset;
    logic [N-1:0]   Req;
    logic [N*W-1:0] op_a;
    logic [N*W-1:0] op_b;
    logic [N-1:0]   Ack;
    logic [2*W-1:0] Result;
    logic           Error;
    logic           Busy;
    logic           Mul_Start;
    logic [W-1:0]   Mul_Multiplicand;
    logic [W-1:0]   Mul_Multiplier;
    logic [2*W-1:0] Mul_Product;
    logic           Mul_Done;

    mult_arbiter #(
        .N                (N),
        .W                (W),
        .TIMEOUT          (TO)
    ) dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .Req              (Req),
        .Operand_A        (op_a),
        .Operand_B        (op_b),
        .Ack              (Ack),
        .Result           (Result),
        .Error            (Error),
        .Busy             (Busy),
        .Mul_Start        (Mul_Start),
        .Mul_Multiplicand (Mul_Multiplicand),
        .Mul_Multiplier   (Mul_Multiplier),
        .Mul_Product      (Mul_Product),
        .Mul_Done         (Mul_Done)
    );

    always #5 Clock = ~Clock;

    // ---------------------------------------------------------------------
    // Behavioural multiplier: Done rises mul_delay cycles after the start
    // pulse is taken and stays high until the next start.
    // ---------------------------------------------------------------------
    int           mul_delay = 1;
    bit           mul_hang  = 1'b0;
    int           m_cnt;
    logic         m_run;
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            m_cnt       <= 0;
            m_run       <= 1'b0;
            m_a         <= '0;
            m_b         <= '0;
            Mul_Done    <= 1'b0;
            Mul_Product <= '0;
        end else if (Mul_Start) begin
            m_run       <= 1'b1;
            m_cnt       <= mul_delay;
            m_a         <= Mul_Multiplicand;
            m_b         <= Mul_Multiplier;
            Mul_Done    <= 1'b0;
            Mul_Product <= '0;
        end else if (m_run && !mul_hang) begin
            if (m_cnt <= 1) begin
                m_run       <= 1'b0;
                Mul_Done    <= 1'b1;
                Mul_Product <= 16'(m_a) * 16'(m_b);
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Checking helpers
    // ---------------------------------------------------------------------
    int n_checks    = 0;
    int n_errors    = 0;
    int start_count = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge Clock);
        #1;
        if (Mul_Start) start_count++;
    endtask

    task automatic wait_start(input string tag, output int cycles);
        bit seen = 1'b0;
        cycles = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            cycles++;
            if (Mul_Start) seen = 1'b1;
        end
        check({tag, "_start_seen"}, 32'(seen), 1);
    endtask

    task automatic wait_ack(input string tag, output logic [N-1:0] ack,
                            output logic [2*W-1:0] res, output logic err,
                            output int cycles);
        bit seen = 1'b0;
        ack    = '0;
        res    = '0;
        err    = 1'b0;
        cycles = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            cycles++;
            if (Ack != '0) begin
                seen = 1'b1;
                ack  = Ack;
                res  = Result;
                err  = Error;
            end
        end
        check({tag, "_ack_seen"}, 32'(seen), 1);
        $display("txn %s: ack=%b result=0x%04h error=%b cycles=%0d",
                 tag, ack, res, err, cycles);
    endtask

    task automatic set_ops(input int idx, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        op_a[idx*W +: W] = a;
        op_b[idx*W +: W] = b;
    endtask

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    logic [N-1:0]   ack;
    logic [2*W-1:0] res;
    logic           err;
    int             c1;
    int             c2;

    logic [2*W-1:0] rr_prod [N];
    logic [N-1:0]   prev_ack;
    logic [N-1:0]   exp_ack;

    initial begin
        Reset = 1'b1;
        Req   = '0;
        op_a  = '0;
        op_b  = '0;
        tick();
        tick();

        // Reset state
        check("rst_ack",    32'(Ack), 0);
        check("rst_result", 32'(Result), 0);
        check("rst_error",  32'(Error), 0);
        check("rst_busy",   32'(Busy), 0);
        check("rst_start",  32'(Mul_Start), 0);
        check("rst_mcand",  32'(Mul_Multiplicand), 0);
        check("rst_mplier", 32'(Mul_Multiplier), 0);
        Reset = 1'b0;
        tick();
        check("idle_busy",  32'(Busy), 0);

        // Single request: 12 * 10 = 120, minimum latency
        start_count = 0;
        set_ops(0, 8'd12, 8'd10);
        Req = 4'b0001;
        wait_start("single", c1);
        check("single_mcand",  32'(Mul_Multiplicand), 12);
        check("single_mplier", 32'(Mul_Multiplier), 10);
        wait_ack("single", ack, res, err, c2);
        check("single_ack",     32'(ack), 32'b0001);
        check("single_result",  32'(res), 120);
        check("single_error",   32'(err), 0);
        check("single_latency", 32'(c1 + c2), 4);
        Req = '0;
        tick();
        check("single_ack_pulse", 32'(Ack), 0);
        check("single_busy_end",  32'(Busy), 0);
        check("single_starts",    32'(start_count), 1);

        // Max operands on requester 2: 255 * 255 = 0xFE01
        set_ops(2, 8'hFF, 8'hFF);
        Req = 4'b0100;
        wait_ack("max", ack, res, err, c2);
        check("max_ack",    32'(ack), 32'b0100);
        check("max_result", 32'(res), 32'hFE01);
        check("max_error",  32'(err), 0);
        Req = '0;

        // Operands changed after grant must not matter: 20 * 30 = 600
        set_ops(3, 8'd20, 8'd30);
        Req = 4'b1000;
        wait_start("late_ops", c1);
        set_ops(3, 8'd1, 8'd1);
        wait_ack("late_ops", ack, res, err, c2);
        check("late_ops_ack",    32'(ack), 32'b1000);
        check("late_ops_result", 32'(res), 600);
        Req = '0;

        // Timeout: multiplier never answers
        set_ops(1, 8'd3, 8'd4);
        mul_hang = 1'b1;
        Req = 4'b0010;
        wait_start("timeout", c1);
        wait_ack("timeout", ack, res, err, c2);
        check("timeout_ack",    32'(ack), 32'b0010);
        check("timeout_error",  32'(err), 1);
        check("timeout_result", 32'(res), 0);
        check("timeout_cycles", 32'(c2), TO + 1);
        mul_hang = 1'b0;
        Req = '0;

        // Done arrives on the last permitted WAIT cycle: Done wins
        mul_delay = TO - 1;
        Req = 4'b0010;
        wait_start("done_edge", c1);
        wait_ack("done_edge", ack, res, err, c2);
        check("done_edge_error",  32'(err), 0);
        check("done_edge_result", 32'(res), 12);
        check("done_edge_cycles", 32'(c2), TO + 1);
        Req = '0;

        // Done one cycle too late: timeout wins
        mul_delay = TO;
        Req = 4'b0010;
        wait_start("done_late", c1);
        wait_ack("done_late", ack, res, err, c2);
        check("done_late_error",  32'(err), 1);
        check("done_late_result", 32'(res), 0);
        mul_delay = 1;
        Req = '0;

        // Reset asserted while waiting on requester 2
        set_ops(2, 8'd5, 8'd6);
        mul_hang = 1'b1;
        Req = 4'b0100;
        wait_start("reset_wait", c1);
        tick();
        tick();
        check("pre_reset_busy", 32'(Busy), 1);
        Reset = 1'b1;
        #1;
        check("mid_reset_busy",   32'(Busy), 0);
        check("mid_reset_ack",    32'(Ack), 0);
        check("mid_reset_start",  32'(Mul_Start), 0);
        check("mid_reset_mcand",  32'(Mul_Multiplicand), 0);
        check("mid_reset_mplier", 32'(Mul_Multiplier), 0);
        check("mid_reset_result", 32'(Result), 0);
        check("mid_reset_error",  32'(Error), 0);
        Req      = '0;
        mul_hang = 1'b0;
        tick();
        Reset = 1'b0;
        tick();

        // Requester 0 drops Req mid-operation; requester 1 served next
        set_ops(0, 8'd7, 8'd9);
        set_ops(1, 8'd11, 8'd13);
        mul_delay = 5;
        Req = 4'b0011;
        wait_start("drop", c1);
        check("drop_first_grant", 32'(Mul_Multiplicand), 7);
        tick();
        tick();
        Req = 4'b0010;
        wait_ack("drop", ack, res, err, c2);
        check("drop_ack",    32'(ack), 32'b0010);
        check("drop_result", 32'(res), 143);
        Req = '0;
        mul_delay = 1;

        // Contention from a fresh reset: all four held high
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
        set_ops(0, 8'd3, 8'd2);
        set_ops(1, 8'd5, 8'd4);
        set_ops(2, 8'd7, 8'd6);
        set_ops(3, 8'd9, 8'd8);
        rr_prod[0] = 16'd6;
        rr_prod[1] = 16'd20;
        rr_prod[2] = 16'd42;
        rr_prod[3] = 16'd72;
        prev_ack = '0;
        Req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_ack = 4'(1 << (k % N));
            wait_ack($sformatf("rr%0d", k), ack, res, err, c2);
            check($sformatf("rr%0d_ack", k),    32'(ack), 32'(exp_ack));
            check($sformatf("rr%0d_result", k), 32'(res), 32'(rr_prod[k % N]));
            check($sformatf("rr%0d_not_repeat", k), 32'(ack == prev_ack), 0);
            prev_ack = ack;
        end
        Req = '0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mult_arbiter
